trigger_sequence_generator: RTL and testbench

Generates a programmable sequence of up to pNUM_TRIGGERS trigger pulses, one per output line, with per-step cycle delays between consecutive rising edges. It is the transmit-side counterpart of the multi-trigger sequence checker. It drives target or loopback trigger lines so the checker's min/max window logic can be exercised on-board and in simulation. It also serves as a multi-stage trigger source for external equipment.

---
 rtl/trigger_sequence_generator.sv | 182 ++++++++++++++++++
 tb/tb_trigger_sequence_generator.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/trigger_sequence_generator.sv
// Programmable multi-step trigger pulse generator.
// A start in IDLE snapshots the delay, pulse-width and last-step settings and
// then emits one pulse per output line. Consecutive rising edges are spaced by
// the per-step delays. At most one output bit is high in any cycle.
// FSM state is visible as state_q for checkers bound into this module.
// Handshake: I_start is a level. It is accepted only on an edge where the FSM
// is in IDLE with I_enable high. It is ignored while O_busy is high.
// O_done is a single-cycle completion pulse.
`timescale 1ns/1ps

module trigger_sequence_generator #(
  parameter int pNUM_TRIGGERS  = 4,
  parameter int pCOUNTER_WIDTH = 16,
  parameter int pPULSE_WIDTH   = 8
) (
  input  logic                                          adc_clk,
  input  logic                                          reset,
  input  logic                                          I_enable,
  input  logic                                          I_start,
  input  logic [(pNUM_TRIGGERS-1)*pCOUNTER_WIDTH-1:0]   I_delay,
  input  logic [pPULSE_WIDTH-1:0]                       I_pulse_width,
  input  logic [3:0]                                    I_last_trigger,
  output logic [pNUM_TRIGGERS-1:0]                      O_trigger,
  output logic                                          O_busy,
  output logic                                          O_done,
  output logic [3:0]                                    O_slot
);

  localparam int NF = pNUM_TRIGGERS - 1;
  localparam int CW = pCOUNTER_WIDTH;
  localparam int PW = pPULSE_WIDTH;
  // Compare width wide enough for both the counter and the pulse width.
  localparam int MW = ((CW > PW) ? CW : PW) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [3:0]               slot_q, slot_d;
  logic [pNUM_TRIGGERS-1:0] trig_q, trig_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  // Snapshot of the sequence settings, already clamped to effective values.
  logic [NF-1:0][CW-1:0]    delay_q, delay_snap;
  logic [PW-1:0]            pw_q, pw_snap;
  logic [3:0]               last_q, last_snap;

  logic                     start_accept;
  logic [CW-1:0]            d_next;
  logic                     is_last;
  logic                     cnt_at_d;
  logic                     cnt_at_pw;

  assign O_trigger = trig_q;
  assign O_busy    = busy_q;
  assign O_done    = done_q;
  assign O_slot    = slot_q;

  assign start_accept = (state_q == IDLE) && I_enable && I_start;

  // Effective settings to capture on start: zero delays/width count as 1,
  // and the last index is clamped to the highest output line.
  always_comb begin
    delay_snap = '0;
    for (int k = 0; k < NF; k++) begin
      delay_snap[k] = (I_delay[k*CW +: CW] == '0) ? CW'(1) : I_delay[k*CW +: CW];
    end
    pw_snap   = (I_pulse_width == '0) ? PW'(1) : I_pulse_width;
    last_snap = (I_last_trigger > 4'(NF)) ? 4'(NF) : I_last_trigger;
  end

  // Delay from the current step's rising edge to the next one.
  always_comb begin
    d_next = '0;
    for (int k = 0; k < NF; k++) begin
      if (slot_q == 4'(k)) d_next = delay_q[k];
    end
  end

  assign is_last   = (slot_q == last_q);
  assign cnt_at_d  = (MW'(cnt_q) == (MW'(d_next) - MW'(1)));
  assign cnt_at_pw = (MW'(cnt_q) == (MW'(pw_q) - MW'(1)));

  // Next-state and registered-output logic; slot advance beats pulse fall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    trig_d  = trig_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        trig_d = '0;
        busy_d = 1'b0;
        slot_d = '0;
        cnt_d  = '0;
        if (start_accept) begin
          state_d = PULSE;
          trig_d  = pNUM_TRIGGERS'(1);
          busy_d  = 1'b1;
        end
      end
      PULSE, GAP: begin
        if (!I_enable) begin
          state_d = IDLE;
          trig_d  = '0;
          busy_d  = 1'b0;
          slot_d  = '0;
          cnt_d   = '0;
        end else if (is_last) begin
          if (cnt_at_pw) begin
            state_d = IDLE;
            trig_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            slot_d  = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (cnt_at_d) begin
          state_d = PULSE;
          slot_d  = slot_q + 4'd1;
          trig_d  = pNUM_TRIGGERS'(1) << (slot_q + 4'd1);
          cnt_d   = '0;
        end else if ((state_q == PULSE) && cnt_at_pw) begin
          state_d = GAP;
          trig_d  = '0;
          cnt_d   = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        trig_d  = '0;
        busy_d  = 1'b0;
        slot_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      trig_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Settings snapshot, loaded only when a sequence is launched.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      delay_q <= '0;
      pw_q    <= '0;
      last_q  <= '0;
    end else if (start_accept) begin
      delay_q <= delay_snap;
      pw_q    <= pw_snap;
      last_q  <= last_snap;
    end
  end

endmodule

// File: tb/tb_trigger_sequence_generator.sv
// Directed bench for trigger_sequence_generator. A timing model derived from
// the rising-edge schedule fills an expected queue with one vector per cycle
// {trigger, busy, done, slot}. The DUT is sampled on the falling edge.
`timescale 1ns/1ps

module tb_trigger_sequence_generator;

  localparam int NT = 4;
  localparam int CW = 16;
  localparam int PW = 8;
  localparam int W  = NT + 1 + 1 + 4;

  logic                     adc_clk;
  logic                     reset;
  logic                     I_enable;
  logic                     I_start;
  logic [(NT-1)*CW-1:0]     I_delay;
  logic [PW-1:0]            I_pulse_width;
  logic [3:0]               I_last_trigger;
  logic [NT-1:0]            O_trigger;
  logic                     O_busy;
  logic                     O_done;
  logic [3:0]               O_slot;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  trigger_sequence_generator #(
    .pNUM_TRIGGERS (NT),
    .pCOUNTER_WIDTH(CW),
    .pPULSE_WIDTH  (PW)
  ) dut (
    .adc_clk       (adc_clk),
    .reset         (reset),
    .I_enable      (I_enable),
    .I_start       (I_start),
    .I_delay       (I_delay),
    .I_pulse_width (I_pulse_width),
    .I_last_trigger(I_last_trigger),
    .O_trigger     (O_trigger),
    .O_busy        (O_busy),
    .O_done        (O_done),
    .O_slot        (O_slot)
  );

  // Clock and watchdog.
  initial begin
    adc_clk = 1'b0;
    forever #5 adc_clk = ~adc_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Expected per-cycle vectors for one sequence started at edge N; entry c-1
  // is the value seen in cycle N+c.
  function automatic void push_seq(input int pw_in, input int d1, input int d2,
                                   input int d3, input int last_in);
    int pw;
    int lst;
    int tend;
    int hi;
    int slot;
    int d[5];
    int t[4];
    logic [NT-1:0] trig;
    logic [W-1:0]  v;
    pw   = (pw_in < 1) ? 1 : pw_in;
    lst  = (last_in > NT-1) ? NT-1 : last_in;
    d[0] = 0;
    d[1] = (d1 < 1) ? 1 : d1;
    d[2] = (d2 < 1) ? 1 : d2;
    d[3] = (d3 < 1) ? 1 : d3;
    d[4] = 0;
    t[0] = 1;
    for (int k = 1; k < NT; k++) t[k] = t[k-1] + d[k];
    tend = t[lst] + pw;
    for (int c = 1; c <= tend; c++) begin
      trig = '0;
      slot = 0;
      for (int k = 0; k <= lst; k++) begin
        hi = (k == lst) ? pw : ((d[k+1] < pw) ? d[k+1] : pw);
        if (c >= t[k]) slot = k;
        if ((c >= t[k]) && (c < t[k] + hi)) trig[k] = 1'b1;
      end
      if (c == tend) v = {{NT{1'b0}}, 1'b0, 1'b1, 4'd0};
      else           v = {trig, 1'b1, 1'b0, 4'(slot)};
      exp_q.push_back(v);
    end
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('0);
  endfunction

  // Scoreboard: pop one expectation per cycle and compare.
  task automatic check_cycle(input string tag);
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_v;
    @(negedge adc_clk);
    obs_v = {O_trigger, O_busy, O_done, O_slot};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s expected queue empty, observed=%h", tag, obs_v);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs_v === exp_v) else begin
        errors++;
        $error("FAIL %s observed trig=%b busy=%b done=%b slot=%0d expected trig=%b busy=%b done=%b slot=%0d",
               tag, obs_v[W-1 -: NT], obs_v[5], obs_v[4], obs_v[3:0],
               exp_v[W-1 -: NT], exp_v[5], exp_v[4], exp_v[3:0]);
      end
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) check_cycle(tag);
  endtask

  // Driver: present settings with I_start high for the next edge.
  task automatic start_seq(input int pw, input int d1, input int d2,
                           input int d3, input int last);
    I_delay        = {CW'(d3), CW'(d2), CW'(d1)};
    I_pulse_width  = PW'(pw);
    I_last_trigger = 4'(last);
    I_start        = 1'b1;
    push_seq(pw, d1, d2, d3, last);
  endtask

  task automatic run_seq(input string tag, input int pw, input int d1,
                         input int d2, input int d3, input int last);
    start_seq(pw, d1, d2, d3, last);
    check_cycle(tag);
    I_start = 1'b0;
    drain(tag);
    push_idle(2);
    drain({tag, "_idle"});
  endtask

  initial begin
    int rpw, r1, r2, r3, rl;
    reset          = 1'b1;
    I_enable       = 1'b0;
    I_start        = 1'b0;
    I_delay        = '0;
    I_pulse_width  = '0;
    I_last_trigger = '0;

    // Reset state.
    push_idle(3);
    drain("reset");
    reset    = 1'b0;
    I_enable = 1'b1;
    push_idle(1);
    drain("post_reset");

    // Basic schedule, truncation, minimum values, clamping, single step.
    run_seq("basic",    2, 5, 3, 10, 3);
    run_seq("trunc",    8, 3, 3, 3, 3);
    run_seq("min_vals", 0, 0, 0, 0, 2);
    run_seq("clamp",    3, 2, 4, 1, 9);
    run_seq("last0",    4, 7, 7, 7, 0);

    // Held start: back-to-back sequences; delay change mid-run is ignored.
    start_seq(2, 5, 3, 10, 3);
    push_seq(2, 5, 3, 10, 3);
    for (int i = 0; i < 25; i++) check_cycle("held");
    I_delay = {CW'(2), CW'(2), CW'(2)};
    I_start = 1'b0;
    drain("held");
    push_idle(2);
    drain("held_idle");
    run_seq("new_delay", 1, 2, 2, 2, 3);

    // Abort by I_enable low in the gap after trigger 1.
    start_seq(2, 5, 3, 10, 3);
    check_cycle("abort_pre");
    I_start = 1'b0;
    for (int i = 0; i < 7; i++) check_cycle("abort_pre");
    I_enable = 1'b0;
    exp_q.delete();
    push_idle(3);
    drain("abort");
    I_enable = 1'b1;
    run_seq("after_abort", 2, 5, 3, 10, 3);

    // Reset during the first pulse.
    start_seq(2, 5, 3, 10, 3);
    check_cycle("rst_pre");
    I_start = 1'b0;
    reset   = 1'b1;
    exp_q.delete();
    push_idle(2);
    drain("mid_reset");
    reset = 1'b0;
    push_idle(2);
    drain("mid_reset_rel");
    run_seq("after_reset", 2, 5, 3, 10, 3);

    // Random settings.
    for (int n = 0; n < 4; n++) begin
      rpw = $urandom_range(0, 6);
      r1  = $urandom_range(0, 8);
      r2  = $urandom_range(0, 8);
      r3  = $urandom_range(0, 8);
      rl  = $urandom_range(0, 6);
      run_seq("random", rpw, r1, r2, r3, rl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
